// File: rtl/fp_mul_pipe_if.sv
// Operand/product handshake bundle for fp_mul_pipe: valid/ready on both the
// operand side and the product side.
interface fp_mul_pipe_if #(
    parameter int W = 32
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A_FP;
    logic [W-1:0] B_FP;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] P_FP;

    modport master (
        output in_valid, A_FP, B_FP, out_ready,
        input  in_ready, out_valid, P_FP
    );

    modport slave (
        input  in_valid, A_FP, B_FP, out_ready,
        output in_ready, out_valid, P_FP
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier (unpack, multiply, normalise/pack).
// No denormals or NaN; rounding truncates; the whole pipe freezes on output backpressure.
module fp_mul_pipe #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_mul_pipe_if.slave bus
);
    localparam int E   = EXPONENT_WIDTH;
    localparam int M   = MANTISSA_WIDTH;
    localparam int W   = 1 + E + M;
    localparam int ESW = E + 2;
    localparam int PW  = 2 * M + 2;
    localparam logic signed [ESW-1:0] BIAS    = ESW'((1 << (E - 1)) - 1);
    localparam logic signed [ESW-1:0] EXP_MAX = ESW'((1 << E) - 1);
    localparam logic signed [ESW-1:0] ONE     = ESW'(1);

    logic                  stall;
    logic                  v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic                  s1_q, s1_d, s2_q, s2_d;
    logic                  z1_q, z1_d, z2_q, z2_d;
    logic signed [ESW-1:0] es1_q, es1_d, es2_q, es2_d;
    logic [M:0]            siga_q, siga_d, sigb_q, sigb_d;
    logic [PW-1:0]         prod_q, prod_d;
    logic [W-1:0]          p3_q, p3_d;

    logic [E-1:0]          exp_a, exp_b;
    logic signed [ESW-1:0] e_norm;
    logic [M-1:0]          frac;
    logic                  unused_prod;

    assign exp_a = bus.A_FP[W-2 -: E];
    assign exp_b = bus.B_FP[W-2 -: E];

    assign stall         = v3_q & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = v3_q;
    assign bus.P_FP      = p3_q;

    // Bits below the kept fraction are simply dropped (truncation).
    assign unused_prod = &{1'b0, prod_q[M-1:0]};

    always_comb begin
        e_norm = prod_q[PW-1] ? (es2_q + ONE) : es2_q;
        frac   = prod_q[PW-1] ? prod_q[PW-2 -: M] : prod_q[PW-3 -: M];
    end

    always_comb begin
        v1_d   = v1_q;   v2_d   = v2_q;   v3_d = v3_q;
        s1_d   = s1_q;   s2_d   = s2_q;
        z1_d   = z1_q;   z2_d   = z2_q;
        es1_d  = es1_q;  es2_d  = es2_q;
        siga_d = siga_q; sigb_d = sigb_q;
        prod_d = prod_q;
        p3_d   = p3_q;
        if (!stall) begin
            // S1: unpack
            v1_d   = bus.in_valid;
            s1_d   = bus.A_FP[W-1] ^ bus.B_FP[W-1];
            z1_d   = (exp_a == '0) | (exp_b == '0);
            es1_d  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS;
            siga_d = {1'b1, bus.A_FP[M-1:0]};
            sigb_d = {1'b1, bus.B_FP[M-1:0]};
            // S2: multiply
            v2_d   = v1_q;
            s2_d   = s1_q;
            z2_d   = z1_q;
            es2_d  = es1_q;
            prod_d = PW'(siga_q) * PW'(sigb_q);
            // S3: normalise, flush/saturate, pack
            v3_d   = v2_q;
            if (z2_q || e_norm[ESW-1] || (e_norm == '0)) begin
                p3_d = '0;
            end else if (e_norm >= EXP_MAX) begin
                p3_d = {s2_q, EXP_MAX[E-1:0], {M{1'b0}}};
            end else begin
                p3_d = {s2_q, e_norm[E-1:0], frac};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0; v2_q   <= 1'b0; v3_q <= 1'b0;
            s1_q   <= 1'b0; s2_q   <= 1'b0;
            z1_q   <= 1'b0; z2_q   <= 1'b0;
            es1_q  <= '0;   es2_q  <= '0;
            siga_q <= '0;   sigb_q <= '0;
            prod_q <= '0;
            p3_q   <= '0;
        end else begin
            v1_q   <= v1_d;   v2_q   <= v2_d;   v3_q <= v3_d;
            s1_q   <= s1_d;   s2_q   <= s2_d;
            z1_q   <= z1_d;   z2_q   <= z2_d;
            es1_q  <= es1_d;  es2_q  <= es2_d;
            siga_q <= siga_d; sigb_q <= sigb_d;
            prod_q <= prod_d;
            p3_q   <= p3_d;
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe: directed vectors, backpressure, async
// reset mid-stream and a randomized sweep against a value-level reference model.
module tb_fp_mul_pipe;
    logic clk;
    logic rst_n;

    fp_mul_pipe_if #(.W(32)) bus ();

    fp_mul_pipe #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int out_count   = 0;
    int acc_count   = 0;
    logic [31:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_p     = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Value-level model: exact integer significand product, normalised by
    // halving until it fits 24 bits, then flush/saturate on the biased exponent.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int     ea = int'(a[30:23]);
        int     eb = int'(b[30:23]);
        logic   s  = a[31] ^ b[31];
        longint p;
        int     e;
        logic [31:0] r;
        if (ea == 0 || eb == 0) return 32'h0;
        p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        e = ea + eb - 150;
        while (p >= (longint'(1) << 24)) begin
            p = p >> 1;
            e++;
        end
        if (e <= 0) return 32'h0;
        if (e >= 255) return {s, 8'hFF, 23'h0};
        r = {s, e[7:0], p[22:0]};
        return r;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        if ($urandom_range(0, 9) < 9) e = 8'($urandom_range(64, 190));
        else                          e = 8'($urandom_range(1, 254));
        return {1'($urandom_range(0, 1)), e, 23'($urandom())};
    endfunction

    // Handshake monitor, sampled on the falling edge while inputs are stable.
    always @(negedge clk) begin
        logic stall_now;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            stall_now = bus.out_valid && !bus.out_ready;
            check("in_ready", 32'(bus.in_ready), 32'(!stall_now));
            if (prev_stall) check("stall_hold", bus.P_FP, prev_p);
            if (bus.in_valid && bus.in_ready) begin
                acc_count++;
                exp_q.push_back(ref_mul(bus.A_FP, bus.B_FP));
            end
            if (bus.out_valid && bus.out_ready) begin
                out_count++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL unexpected_output observed=%h expected=none", bus.P_FP);
                end else begin
                    check("product", bus.P_FP, exp_q.pop_front());
                end
            end
            prev_stall = stall_now;
            prev_p     = bus.P_FP;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Sends one pair into an empty pipe and checks the 3-cycle latency and value.
    task automatic send_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] expv);
        bus.in_valid = 1'b1;
        bus.A_FP     = a;
        bus.B_FP     = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_lat2"}, 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check(tag, bus.P_FP, expv);
        @(posedge clk); #1;
    endtask

    logic [31:0] bp_a[6];
    logic [31:0] bp_b[6];
    int          idx, sent, cyc, base_out, base_acc;
    logic        acc;

    initial begin
        bus.in_valid  = 1'b0;
        bus.A_FP      = '0;
        bus.B_FP      = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_p_fp", bus.P_FP, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);

        send_one("mul_7p25", 32'h40E80000, 32'h3EC00000, 32'h402E0000);
        send_one("mul_neg36", 32'hC2100000, 32'h41200000, 32'hC3B40000);
        send_one("mul_neghalf", 32'hBF000000, 32'h3F000000, 32'hBE800000);
        send_one("zero_a", 32'h00000000, 32'h41400000, 32'h00000000);
        send_one("zero_signclr", 32'hBF000000, 32'h00000000, 32'h00000000);
        send_one("underflow", 32'h00800000, 32'h00800000, 32'h00000000);
        send_one("overflow", 32'h7F000000, 32'h40000000, 32'h7F800000);

        // Backpressure: 6 back-to-back pairs, out_ready low on cycles 4..9.
        for (int k = 0; k < 6; k++) begin
            bp_a[k] = rand_fp();
            bp_b[k] = rand_fp();
        end
        base_out = out_count;
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            bus.out_ready = !(c >= 4 && c <= 9);
            bus.in_valid  = (idx < 6);
            if (idx < 6) begin
                bus.A_FP = bp_a[idx];
                bus.B_FP = bp_b[idx];
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_accepted", 32'(idx), 32'd6);
        check("bp_out_count", 32'(out_count - base_out), 32'd6);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Async reset with three products in flight.
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.A_FP     = rand_fp();
            bus.B_FP     = rand_fp();
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("rst_inflight_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(bus.out_valid), 32'd0);
        check("rst_async_p", bus.P_FP, 32'h0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("rst_no_stale", 32'(bus.out_valid), 32'd0);
        end
        send_one("post_reset", 32'h40E80000, 32'h3EC00000, 32'h402E0000);

        // Random sweep with random backpressure.
        base_out = out_count;
        base_acc = acc_count;
        sent = 0;
        cyc  = 0;
        bus.in_valid = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            if (!bus.in_valid && $urandom_range(0, 9) < 8) begin
                bus.in_valid = 1'b1;
                bus.A_FP     = rand_fp();
                bus.B_FP     = rand_fp();
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check("sweep_sent", 32'(sent), 32'd10000);
        check("sweep_accepted", 32'(acc_count - base_acc), 32'(sent));
        check("sweep_out_count", 32'(out_count - base_out), 32'(acc_count - base_acc));
        check("sweep_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
